// File: rtl/alu_cmd_issuer.sv
// Buffers ALU operation requests in a small FIFO and issues them one at a time
// onto the ALU input pins, strobing res_strobe when the ALU result is valid.
module alu_cmd_issuer #(
    parameter int DW      = 8,
    parameter int CW      = 4,
    parameter int DEPTH   = 4,
    parameter int LAT     = 1,
    parameter int MUL_LAT = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   flush,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_mode,
    input  logic [CW-1:0]          req_cmd,
    input  logic [DW-1:0]          req_opa,
    input  logic [DW-1:0]          req_opb,
    input  logic                   req_cin,
    input  logic                   req_split,
    output logic                   CE,
    output logic                   MODE,
    output logic [CW-1:0]          CMD,
    output logic [1:0]             INP_VALID,
    output logic [DW-1:0]          OPA,
    output logic [DW-1:0]          OPB,
    output logic                   CIN,
    output logic                   res_strobe,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count
);

    // state    | meaning
    // IDLE     | no op in flight; pops the FIFO head when not empty
    // ISSUE_AB | both operands presented in one cycle
    // ISSUE_A  | split op, operand A cycle
    // ISSUE_B  | split op, operand B cycle (A held)
    // WAIT     | counting down ALU latency; res_strobe on terminal count

    localparam int AW   = $clog2(DEPTH);
    localparam int LMAX = (MUL_LAT > LAT) ? MUL_LAT : LAT;
    localparam int LW   = (LMAX > 1) ? $clog2(LMAX) : 1;

    typedef struct packed {
        logic          mode;
        logic [CW-1:0] cmd;
        logic [DW-1:0] opa;
        logic [DW-1:0] opb;
        logic          cin;
        logic          split;
    } req_t;

    typedef enum logic [2:0] {IDLE, ISSUE_AB, ISSUE_A, ISSUE_B, WAIT} state_t;

    req_t           mem [DEPTH];
    req_t           head;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           push;
    logic           pop;
    logic           empty;
    state_t         state;
    logic [DW-1:0]  op_opb;
    logic [LW-1:0]  lat_cnt;
    logic [LW-1:0]  lat_m1;
    logic           is_mul;

    assign head      = mem[rd_ptr];
    assign empty     = (count == '0);
    assign req_ready = (count != (AW+1)'(DEPTH));
    assign push      = req_valid && req_ready && !flush;
    assign pop       = (state == IDLE) && !empty && !flush;

    // MODE/CMD are already on the pins when the last issue cycle is reached
    assign is_mul = MODE && ((CMD == CW'(9)) || (CMD == CW'(10)));
    assign lat_m1 = is_mul ? LW'(MUL_LAT - 1) : LW'(LAT - 1);

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= '{mode: req_mode, cmd: req_cmd, opa: req_opa,
                             opb: req_opb, cin: req_cin, split: req_split};
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            CE         <= 1'b0;
            MODE       <= 1'b0;
            CMD        <= '0;
            INP_VALID  <= 2'b00;
            OPA        <= '0;
            OPB        <= '0;
            CIN        <= 1'b0;
            res_strobe <= 1'b0;
            busy       <= 1'b0;
            op_opb     <= '0;
            lat_cnt    <= '0;
        end else if (flush) begin
            state      <= IDLE;
            CE         <= 1'b0;
            INP_VALID  <= 2'b00;
            res_strobe <= 1'b0;
            busy       <= 1'b0;
        end else begin
            res_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        CE     <= 1'b1;
                        MODE   <= head.mode;
                        CMD    <= head.cmd;
                        OPA    <= head.opa;
                        CIN    <= head.cin;
                        op_opb <= head.opb;
                        busy   <= 1'b1;
                        if (head.split) begin
                            INP_VALID <= 2'b01;
                            OPB       <= '0;
                            state     <= ISSUE_A;
                        end else begin
                            INP_VALID <= 2'b11;
                            OPB       <= head.opb;
                            state     <= ISSUE_AB;
                        end
                    end else begin
                        CE        <= 1'b0;
                        INP_VALID <= 2'b00;
                    end
                end
                ISSUE_A: begin
                    INP_VALID <= 2'b10;
                    OPB       <= op_opb;
                    state     <= ISSUE_B;
                end
                ISSUE_AB, ISSUE_B: begin
                    INP_VALID  <= 2'b00;
                    lat_cnt    <= lat_m1;
                    res_strobe <= (lat_m1 == '0);
                    state      <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        CE    <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        lat_cnt    <= lat_cnt - 1'b1;
                        res_strobe <= (lat_cnt == LW'(1));
                    end
                end
                default: begin
                    CE        <= 1'b0;
                    INP_VALID <= 2'b00;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: directed scenarios plus random traffic,
// compared cycle by cycle against a queue-and-timeline reference model.
module tb_alu_cmd_issuer;

    localparam int DW      = 8;
    localparam int CW      = 4;
    localparam int DEPTH   = 4;
    localparam int LAT     = 1;
    localparam int MUL_LAT = 2;

    typedef struct packed {
        logic          mode;
        logic [CW-1:0] cmd;
        logic [DW-1:0] opa;
        logic [DW-1:0] opb;
        logic          cin;
        logic          split;
    } req_t;

    logic                   CLK = 1'b0;
    logic                   RST = 1'b0;
    logic                   flush = 1'b0;
    logic                   req_valid = 1'b0;
    logic                   req_ready;
    logic                   req_mode = 1'b0;
    logic [CW-1:0]          req_cmd = '0;
    logic [DW-1:0]          req_opa = '0;
    logic [DW-1:0]          req_opb = '0;
    logic                   req_cin = 1'b0;
    logic                   req_split = 1'b0;
    logic                   CE;
    logic                   MODE;
    logic [CW-1:0]          CMD;
    logic [1:0]             INP_VALID;
    logic [DW-1:0]          OPA;
    logic [DW-1:0]          OPB;
    logic                   CIN;
    logic                   res_strobe;
    logic                   busy;
    logic [$clog2(DEPTH):0] count;

    alu_cmd_issuer #(.DW(DW), .CW(CW), .DEPTH(DEPTH), .LAT(LAT), .MUL_LAT(MUL_LAT)) dut (
        .CLK(CLK), .RST(RST), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_mode(req_mode), .req_cmd(req_cmd), .req_opa(req_opa), .req_opb(req_opb),
        .req_cin(req_cin), .req_split(req_split),
        .CE(CE), .MODE(MODE), .CMD(CMD), .INP_VALID(INP_VALID),
        .OPA(OPA), .OPB(OPB), .CIN(CIN),
        .res_strobe(res_strobe), .busy(busy), .count(count)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // reference model: accepted requests, and the op currently in flight
    req_t q[$];
    bit   act = 1'b0;
    int   pop_c = 0;
    int   cyc = 0;
    req_t cur = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
        end
    endtask

    function automatic req_t mk(input logic m, input logic [CW-1:0] c, input logic [DW-1:0] a,
                                input logic [DW-1:0] b, input logic ci, input logic s);
        req_t r;
        r.mode = m; r.cmd = c; r.opa = a; r.opb = b; r.cin = ci; r.split = s;
        return r;
    endfunction

    function automatic int op_lat(input req_t r);
        return (r.mode && (r.cmd == 4'd9 || r.cmd == 4'd10)) ? MUL_LAT : LAT;
    endfunction

    function automatic int n_issue(input req_t r);
        return r.split ? 2 : 1;
    endfunction

    task automatic check_outputs();
        int d, f, l;
        logic [1:0] exp_iv;
        chk("count", 32'(count), 32'(q.size()));
        chk("req_ready", 32'(req_ready), 32'(q.size() < DEPTH));
        chk("busy", 32'(busy), 32'(act));
        if (act) begin
            d = cyc - pop_c;
            f = n_issue(cur);
            l = op_lat(cur);
            if (d > f)          exp_iv = 2'b00;
            else if (!cur.split) exp_iv = 2'b11;
            else if (d == 1)    exp_iv = 2'b01;
            else                exp_iv = 2'b10;
            chk("ce", 32'(CE), 32'(1));
            chk("inp_valid", 32'(INP_VALID), 32'(exp_iv));
            chk("res_strobe", 32'(res_strobe), 32'(d == f + l));
            chk("opa", 32'(OPA), 32'(cur.opa));
            chk("opb", 32'(OPB), 32'((cur.split && d == 1) ? 8'h00 : cur.opb));
            chk("mode", 32'(MODE), 32'(cur.mode));
            chk("cmd", 32'(CMD), 32'(cur.cmd));
            chk("cin", 32'(CIN), 32'(cur.cin));
        end else begin
            chk("ce_idle", 32'(CE), 32'(0));
            chk("inp_valid_idle", 32'(INP_VALID), 32'(0));
            chk("res_strobe_idle", 32'(res_strobe), 32'(0));
        end
    endtask

    task automatic model_edge(input bit v, input req_t r, input bit fl);
        bit acc;
        if (fl) begin
            q.delete();
            act = 1'b0;
        end else begin
            acc = v && (q.size() < DEPTH);
            if (!act && q.size() > 0) begin
                cur   = q.pop_front();
                act   = 1'b1;
                pop_c = cyc;
            end else if (act && (cyc - pop_c) == n_issue(cur) + op_lat(cur)) begin
                act = 1'b0;
            end
            if (acc) q.push_back(r);
        end
        cyc++;
    endtask

    // called at a negedge: check this cycle, drive the inputs for the next edge
    task automatic step(input bit v, input req_t r, input bit fl);
        check_outputs();
        req_valid = v;
        req_mode  = r.mode;
        req_cmd   = r.cmd;
        req_opa   = r.opa;
        req_opb   = r.opb;
        req_cin   = r.cin;
        req_split = r.split;
        flush     = fl;
        model_edge(v, r, fl);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ce"}, 32'(CE), 32'(0));
        chk({tag, "_mode"}, 32'(MODE), 32'(0));
        chk({tag, "_cmd"}, 32'(CMD), 32'(0));
        chk({tag, "_inp_valid"}, 32'(INP_VALID), 32'(0));
        chk({tag, "_opa"}, 32'(OPA), 32'(0));
        chk({tag, "_opb"}, 32'(OPB), 32'(0));
        chk({tag, "_cin"}, 32'(CIN), 32'(0));
        chk({tag, "_res_strobe"}, 32'(res_strobe), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_count"}, 32'(count), 32'(0));
    endtask

    initial begin
        bit hit;

        @(negedge CLK);
        @(negedge CLK);
        chk_reset_vals("reset");
        RST = 1'b1;
        idle(2);

        // unsplit ADD
        step(1'b1, mk(1'b1, 4'd0, 8'h0F, 8'h01, 1'b0, 1'b0), 1'b0);
        idle(5);

        // split op
        step(1'b1, mk(1'b0, 4'd1, 8'h20, 8'h05, 1'b0, 1'b1), 1'b0);
        idle(6);

        // multiply: two-cycle latency
        step(1'b1, mk(1'b1, 4'd9, 8'h03, 8'h04, 1'b0, 1'b0), 1'b0);
        idle(6);

        // fill FIFO behind a long op; the fifth push must be refused
        step(1'b1, mk(1'b1, 4'd10, 8'h07, 8'h06, 1'b1, 1'b1), 1'b0);
        for (int i = 0; i < 5; i++)
            step(1'b1, mk(1'b0, 4'(i + 2), 8'(8'h40 + i), 8'(8'h50 + i), 1'(i), 1'b0), 1'b0);
        idle(25);

        // flush in the first WAIT cycle of a multiply with two ops queued
        step(1'b1, mk(1'b1, 4'd9, 8'h11, 8'h22, 1'b0, 1'b0), 1'b0);
        step(1'b1, mk(1'b0, 4'd2, 8'h33, 8'h44, 1'b0, 1'b0), 1'b0);
        step(1'b1, mk(1'b0, 4'd3, 8'h55, 8'h66, 1'b1, 1'b0), 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            if (act && (cyc - pop_c) == n_issue(cur) + 1 && q.size() == 2) begin
                hit = 1'b1;
                step(1'b0, '0, 1'b1);
            end else begin
                step(1'b0, '0, 1'b0);
            end
        end
        chk("flush_reached", 32'(hit), 32'(1));
        idle(5);

        // async reset during ISSUE_B with one op queued
        step(1'b1, mk(1'b1, 4'd4, 8'hA5, 8'h5A, 1'b1, 1'b1), 1'b0);
        step(1'b1, mk(1'b0, 4'd5, 8'h12, 8'h34, 1'b0, 1'b0), 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            if (act && cur.split && (cyc - pop_c) == 2) hit = 1'b1;
            else step(1'b0, '0, 1'b0);
        end
        chk("issue_b_reached", 32'(hit), 32'(1));
        check_outputs();
        req_valid = 1'b0;
        #2 RST = 1'b0;
        #1 chk_reset_vals("mid_reset");
        @(negedge CLK);
        RST = 1'b1;
        q.delete();
        act = 1'b0;
        idle(6);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 4,
                 mk(1'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom)),
                 $urandom_range(0, 49) == 0);
        end
        idle(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
